stall_sequencer: RTL and testbench
==================================

# stall_sequencer

Sequential stall/flush controller for the five-stage MIPS pipeline. It sits between the hazard detector, the branch-resolution logic and data memory, and drives the pipeline-register enables and flushes.
- Turns per-cycle hazard requests into deterministic multi-cycle stall sequences: load-use 1 cycle, branch RAW 1 or 2 cycles.
- Squashes wrong-path fetches on taken branches.
- Freezes the whole pipe while data memory is busy.
- Parks the core on halt.

## Interface
- `CNT_W`, default 32: width of the stall-cycle performance counter.
- `clk` in 1: pipeline clock; all state updates on the rising edge.
- `reset` in 1: asynchronous, active-high reset.
- `load_use_req` in 1: load-use hazard detected for the instruction in ID; needs 1 stall cycle.
- `branch_dep_cycles` in 2: stall cycles required by a branch in ID with an unresolved operand (0 none, 1 ALU producer, 2 load producer; 3 treated as 2).
- `branch_taken` in 1: branch resolved taken in ID this cycle.
- `mem_busy` in 1: data memory not ready; the MEM-stage access must hold.
- `halt` in 1: halt/syscall-exit reached ID.
- `PCWrite` out 1: PC register enable.
- `IF_ID_Write` out 1: IF/ID register enable.
- `IF_ID_Flush` out 1: clear IF/ID to NOP on the next edge.
- `ID_EX_Flush` out 1: insert a bubble into ID/EX on the next edge.
- `pipe_en` out 1: enable for the ID/EX, EX/MEM and MEM/WB registers.
- `stall_active` out 1: high in every cycle where `PCWrite`=0.
- `stall_cycles` out `CNT_W`: performance counter, see Configuration.

## Operation
- State machine states: RUN, STALL, HALT. Down-counter `remain[1:0]`.
- Outputs are Mealy, decoded from the current state and current inputs. The first stall cycle takes effect in the same cycle the request appears.
- Request resolution in RUN: `need = max(load_use_req ? 1 : 0, min(branch_dep_cycles, 2))`.
- Output priority, highest first:
  1. `reset`
  2. `mem_busy`
  3. HALT state or `halt`
  4. STALL state or `need`>0
  5. `branch_taken`
  6. normal run
- mem_busy:
  - Outputs: `PCWrite`=0, `IF_ID_Write`=0, `pipe_en`=0, both flushes 0.
  - State and `remain` hold. A request arriving during mem_busy is not latched; the hazard detector re-presents it.
- halt in RUN or STALL (no mem_busy):
  - Go to HALT. HALT is sticky and exits only by reset.
  - Outputs in HALT: `PCWrite`=0, `IF_ID_Write`=0, `ID_EX_Flush`=1, `pipe_en`=1, so older instructions drain.
- RUN with `need`>0:
  - Outputs: `PCWrite`=0, `IF_ID_Write`=0, `ID_EX_Flush`=1, `pipe_en`=1.
  - If `need`=2: go to STALL with `remain`=1. Otherwise stay in RUN.
- STALL:
  - Outputs as in the stall case above. New requests and `branch_taken` are ignored.
  - `remain` decrements. At `remain`=0 on the edge, return to RUN and re-evaluate inputs the next cycle.
- RUN with `need`=0 and `branch_taken`: `IF_ID_Flush`=1; all enables 1.
- A stall cycle and `branch_taken` in the same cycle: the stall wins and no flush is issued, because operands are unresolved.
- Normal run: all enables 1, all flushes 0.

## Timing
- While `reset` is high:
  - Outputs forced to `PCWrite`=0, `IF_ID_Write`=0, `IF_ID_Flush`=1, `ID_EX_Flush`=1, `pipe_en`=0, `stall_active`=1.
  - State goes to RUN, `remain` to 0, `stall_cycles` to 0.
- Reset mid-STALL or in HALT: the sequence is abandoned. After deassertion the first cycle is a normal RUN cycle.
- Stall latency is 0 cycles (combinational). Length: load-use 1 cycle, branch-ALU 1 cycle, branch-load 2 consecutive cycles.
- mem_busy inside a STALL sequence stretches the sequence by exactly the number of busy cycles.

## Configuration
- `STALL_PERF_CNT_EN` defined:
  - `stall_cycles` increments by 1 on each edge where `stall_active`=1, `reset`=0 and `mem_busy`=0.
  - The counter saturates at all-ones.
- `STALL_PERF_CNT_EN` undefined: `stall_cycles` is tied to 0 and no counter flops exist. Behaviour is otherwise identical.

## Test plan
- Reset released, no requests: from the first cycle `PCWrite`=`IF_ID_Write`=`pipe_en`=1, both flushes 0, `stall_cycles`=0.
- `load_use_req` pulsed for 1 cycle: `PCWrite`=0 and `ID_EX_Flush`=1 for exactly 1 cycle; the next cycle is normal; counter = 1.
- `branch_dep_cycles`=2 for 1 cycle with `branch_taken`=1 and `mem_busy` pulsed in the 2nd cycle: 3 cycles with `PCWrite`=0, of which the middle cycle has `pipe_en`=0; no `IF_ID_Flush` during the stall; counter = 2.
- `branch_taken`=1, no hazard: `IF_ID_Flush`=1 for 1 cycle, `PCWrite`=1.
- `halt`=1 for 1 cycle, then 5 idle cycles: `PCWrite`=0 and `ID_EX_Flush`=1 on all 6 cycles; a `reset` pulse returns to normal run.
- `reset` asserted asynchronously mid-STALL (`remain`=1): outputs immediately take the reset values; after release no residual stall cycle occurs.

Source files
------------

// File: rtl/stall_sequencer_if.sv
// Control bundle between the hazard/branch/memory sources and the stall sequencer.
// master drives requests and observes the pipeline controls; slave is the sequencer.
interface stall_sequencer_if #(
    parameter int CNT_W = 32
);
    logic             load_use_req;
    logic [1:0]       branch_dep_cycles;
    logic             branch_taken;
    logic             mem_busy;
    logic             halt;
    logic             PCWrite;
    logic             IF_ID_Write;
    logic             IF_ID_Flush;
    logic             ID_EX_Flush;
    logic             pipe_en;
    logic             stall_active;
    logic [CNT_W-1:0] stall_cycles;

    modport master (
        output load_use_req, branch_dep_cycles, branch_taken, mem_busy, halt,
        input  PCWrite, IF_ID_Write, IF_ID_Flush, ID_EX_Flush, pipe_en,
               stall_active, stall_cycles
    );

    modport slave (
        input  load_use_req, branch_dep_cycles, branch_taken, mem_busy, halt,
        output PCWrite, IF_ID_Write, IF_ID_Flush, ID_EX_Flush, pipe_en,
               stall_active, stall_cycles
    );
endinterface

// File: rtl/stall_sequencer.sv
// Stall/flush sequencer for the five-stage pipe: RUN/STALL/HALT FSM with Mealy controls.
// Define STALL_PERF_CNT_EN to build the saturating stall-cycle counter on stall_cycles.
module stall_sequencer #(
    parameter int CNT_W = 32
) (
    input  logic              clk,
    input  logic              reset,
    stall_sequencer_if.slave  bus
);
    typedef enum logic [1:0] {RUN, STALL, HALT} state_t;

    state_t     stateReg, stateNext;
    logic [1:0] remainReg, remainNext;
    logic [1:0] depCycles;
    logic [1:0] need;

    // A dependency code of 3 behaves as a load producer (2 cycles).
    assign depCycles = (bus.branch_dep_cycles == 2'd3) ? 2'd2 : bus.branch_dep_cycles;
    assign need      = (depCycles == 2'd0 && bus.load_use_req) ? 2'd1 : depCycles;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            stateReg  <= RUN;
            remainReg <= 2'd0;
        end else begin
            stateReg  <= stateNext;
            remainReg <= remainNext;
        end
    end

    always_comb begin
        stateNext  = stateReg;
        remainNext = remainReg;
        if (!bus.mem_busy) begin
            if (stateReg == HALT) begin
                stateNext = HALT;
            end else if (bus.halt) begin
                stateNext  = HALT;
                remainNext = 2'd0;
            end else if (stateReg == STALL) begin
                remainNext = (remainReg == 2'd0) ? 2'd0 : remainReg - 2'd1;
                if (remainReg <= 2'd1) begin
                    stateNext = RUN;
                end
            end else if (need == 2'd2) begin
                // The current cycle is the first stall; one more follows in STALL.
                stateNext  = STALL;
                remainNext = 2'd1;
            end
        end
    end

    always_comb begin
        bus.PCWrite     = 1'b1;
        bus.IF_ID_Write = 1'b1;
        bus.IF_ID_Flush = 1'b0;
        bus.ID_EX_Flush = 1'b0;
        bus.pipe_en     = 1'b1;
        if (reset) begin
            bus.PCWrite     = 1'b0;
            bus.IF_ID_Write = 1'b0;
            bus.IF_ID_Flush = 1'b1;
            bus.ID_EX_Flush = 1'b1;
            bus.pipe_en     = 1'b0;
        end else if (bus.mem_busy) begin
            bus.PCWrite     = 1'b0;
            bus.IF_ID_Write = 1'b0;
            bus.pipe_en     = 1'b0;
        end else if (stateReg == HALT || bus.halt ||
                     stateReg == STALL || need != 2'd0) begin
            // Halt and stall share one pattern: freeze fetch, bubble ID/EX, drain the back end.
            bus.PCWrite     = 1'b0;
            bus.IF_ID_Write = 1'b0;
            bus.ID_EX_Flush = 1'b1;
        end else if (bus.branch_taken) begin
            bus.IF_ID_Flush = 1'b1;
        end
    end

    assign bus.stall_active = ~bus.PCWrite;

`ifdef STALL_PERF_CNT_EN
    logic [CNT_W-1:0] cntReg;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cntReg <= '0;
        end else if (bus.stall_active && !bus.mem_busy && !(&cntReg)) begin
            cntReg <= cntReg + CNT_W'(1);
        end
    end

    assign bus.stall_cycles = cntReg;
`else
    assign bus.stall_cycles = {CNT_W{1'b0}};
`endif
endmodule

// File: tb/tb_stall_sequencer.sv
// Directed bench for stall_sequencer: hand-computed control patterns and counter values.
module tb_stall_sequencer;
    localparam int CNT_W = 4;
`ifdef STALL_PERF_CNT_EN
    localparam bit PERF = 1'b1;
`else
    localparam bit PERF = 1'b0;
`endif
    // {PCWrite, IF_ID_Write, IF_ID_Flush, ID_EX_Flush, pipe_en}
    localparam logic [4:0] NORM  = 5'b11001;
    localparam logic [4:0] STL   = 5'b00011;
    localparam logic [4:0] MEMB  = 5'b00000;
    localparam logic [4:0] FLUSH = 5'b11101;
    localparam logic [4:0] RST   = 5'b00110;

    logic clk;
    logic reset;
    int   checks;
    int   failures;

    stall_sequencer_if #(.CNT_W(CNT_W)) bus ();

    stall_sequencer #(.CNT_W(CNT_W)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [4:0] expv);
        logic [4:0] obs;
        obs = {bus.PCWrite, bus.IF_ID_Write, bus.IF_ID_Flush, bus.ID_EX_Flush, bus.pipe_en};
        checks++;
        assert (obs === expv) else begin
            failures++;
            $error("FAIL %s ctrl observed=%b expected=%b", tag, obs, expv);
        end
        checks++;
        assert (bus.stall_active === ~expv[4]) else begin
            failures++;
            $error("FAIL %s stall_active observed=%b expected=%b", tag, bus.stall_active, ~expv[4]);
        end
        $display("step %-14s ctrl=%b stall_active=%b stall_cycles=%0d", tag, obs,
                 bus.stall_active, bus.stall_cycles);
    endtask

    task automatic chkCnt(input string tag, input int n);
        logic [CNT_W-1:0] expv;
        expv = PERF ? CNT_W'(n) : '0;
        checks++;
        assert (bus.stall_cycles === expv) else begin
            failures++;
            $error("FAIL %s stall_cycles observed=%0d expected=%0d", tag, bus.stall_cycles, expv);
        end
    endtask

    // Advance to 1 time unit after the next rising edge; inputs change here.
    task automatic nextCycle();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        bus.load_use_req      = 1'b0;
        bus.branch_dep_cycles = 2'd0;
        bus.branch_taken      = 1'b0;
        bus.mem_busy          = 1'b0;
        bus.halt              = 1'b0;
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        reset    = 1'b1;
        idle();
        #2;
        chk("reset", RST);
        chkCnt("reset_cnt", 0);
        nextCycle();
        nextCycle();
        reset = 1'b0;
        #1 chk("run0", NORM);
        chkCnt("run0_cnt", 0);

        // load-use: one stall cycle
        nextCycle(); bus.load_use_req = 1'b1;
        #1 chk("lu_stall", STL);
        nextCycle(); idle();
        #1 chk("lu_after", NORM);
        chkCnt("lu_cnt", 1);

        // branch on load producer, taken, memory busy in the second cycle
        nextCycle(); bus.branch_dep_cycles = 2'd2; bus.branch_taken = 1'b1;
        #1 chk("bl_stall1", STL);
        nextCycle(); idle(); bus.mem_busy = 1'b1;
        #1 chk("bl_busy", MEMB);
        nextCycle(); idle();
        #1 chk("bl_stall2", STL);
        nextCycle();
        #1 chk("bl_after", NORM);
        chkCnt("bl_cnt", 3);

        // code 3 acts as 2; requests in STALL are ignored
        nextCycle(); bus.branch_dep_cycles = 2'd3;
        #1 chk("b3_stall1", STL);
        nextCycle(); idle(); bus.load_use_req = 1'b1; bus.branch_taken = 1'b1;
        #1 chk("b3_stall2", STL);
        nextCycle(); idle();
        #1 chk("b3_after", NORM);
        chkCnt("b3_cnt", 5);

        // branch on ALU producer: one stall cycle
        nextCycle(); bus.branch_dep_cycles = 2'd1;
        #1 chk("ba_stall", STL);
        nextCycle(); idle();
        #1 chk("ba_after", NORM);
        chkCnt("ba_cnt", 6);

        // mem_busy beats a load-use request, which is not latched
        nextCycle(); bus.mem_busy = 1'b1; bus.load_use_req = 1'b1;
        #1 chk("busy_lu", MEMB);
        nextCycle(); idle();
        #1 chk("busy_after", NORM);
        chkCnt("busy_cnt", 6);

        // taken branch with no hazard squashes the fetch
        nextCycle(); bus.branch_taken = 1'b1;
        #1 chk("bt_flush", FLUSH);
        nextCycle(); idle();
        #1 chk("bt_after", NORM);

        // halt is sticky; counter saturates at 15 with CNT_W=4
        nextCycle(); bus.halt = 1'b1;
        #1 chk("halt0", STL);
        for (int i = 1; i <= 10; i++) begin
            nextCycle(); idle();
            #1 chk($sformatf("halt%0d", i), STL);
        end
        chkCnt("halt_sat_cnt", 15);
        nextCycle(); reset = 1'b1;
        #1 chk("halt_reset", RST);
        chkCnt("halt_reset_cnt", 0);
        nextCycle(); reset = 1'b0;
        #1 chk("halt_release", NORM);

        // asynchronous reset mid-STALL abandons the sequence
        nextCycle(); bus.branch_dep_cycles = 2'd2;
        #1 chk("ms_stall1", STL);
        nextCycle(); idle();
        #1 chk("ms_stall2", STL);
        reset = 1'b1;
        #1 chk("ms_reset", RST);
        nextCycle(); reset = 1'b0;
        #1 chk("ms_release", NORM);
        nextCycle();
        #1 chk("ms_after", NORM);
        chkCnt("ms_cnt", 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
